// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable framing (data width, parity, stop bits) fed by a FIFO.
// Define UART_TX_FIFO_BREAK_EN to add the i_Break input for break generation.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  // Handshake: a character is accepted on a rising edge where i_TX_DV and
  // o_TX_Ready are both high; a strobe while o_TX_Ready is low is dropped.
  input  logic                          i_TX_DV,
  input  logic [DATA_BITS-1:0]          i_TX_Byte,
`ifdef UART_TX_FIFO_BREAK_EN
  input  logic                          i_Break,
`endif
  output logic                          o_TX_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_TX_Active,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Done
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam bit PAR_EN  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit PAR_ODD = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop, can_start, bit_end;
  logic [CNT_W-1:0]     clk_q, clk_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_d, active_d, done_d;

  assign push         = i_TX_DV && o_TX_Ready;
  assign bit_end      = (clk_q == CNT_W'(CLKS_PER_BIT - 1));
  assign o_FIFO_Count = count_q;

`ifdef UART_TX_FIFO_BREAK_EN
  localparam int MAB_W = $clog2(CLKS_PER_BIT + 1);
  logic [MAB_W-1:0] mab_q, mab_d;
  // No new frame while break is held or the mark-after-break interval runs.
  assign can_start = (count_q != '0) && !i_Break && (mab_q == '0);
`else
  assign can_start = (count_q != '0);
`endif

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_TX_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      o_TX_Ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q    <= count_d;
      o_TX_Ready <= (count_d < CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    state_d  = state_q;
    serial_d = o_TX_Serial;
    active_d = o_TX_Active;
    done_d   = 1'b0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pop      = 1'b0;
    clk_d    = (state_q == IDLE || bit_end) ? '0 : clk_q + 1'b1;
`ifdef UART_TX_FIFO_BREAK_EN
    mab_d    = mab_q;
`endif
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
`ifdef UART_TX_FIFO_BREAK_EN
        if (i_Break) begin
          serial_d = 1'b0;
          active_d = 1'b1;
          mab_d    = MAB_W'(CLKS_PER_BIT);
        end else if (mab_q != '0) begin
          mab_d = mab_q - 1'b1;
        end
`endif
        pop = can_start;
      end
      START: if (bit_end) begin
        state_d  = DATA;
        serial_d = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == 4'(DATA_BITS - 1)) begin
          bit_d    = '0;
          state_d  = PAR_EN ? PARITY : STOP;
          serial_d = PAR_EN ? par_q : 1'b1;
        end else begin
          bit_d    = bit_q + 1'b1;
          shift_d  = shift_q >> 1;
          serial_d = shift_q[1];
        end
      end
      PARITY: if (bit_end) begin
        state_d  = STOP;
        serial_d = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_q == 4'(STOP_BITS - 1)) begin
          done_d   = 1'b1;
          bit_d    = '0;
          state_d  = IDLE;
          serial_d = 1'b1;
          active_d = 1'b0;
          pop      = can_start;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        active_d = 1'b0;
        bit_d    = '0;
        clk_d    = '0;
      end
    endcase
    // A pop always launches a start bit, including back-to-back after a stop bit.
    if (pop) begin
      state_d  = START;
      serial_d = 1'b0;
      active_d = 1'b1;
      bit_d    = '0;
      shift_d  = mem[rd_ptr];
      par_d    = (^mem[rd_ptr]) ^ PAR_ODD;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      clk_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
`ifdef UART_TX_FIFO_BREAK_EN
      mab_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      clk_q       <= clk_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      o_TX_Serial <= serial_d;
      o_TX_Active <= active_d;
      o_TX_Done   <= done_d;
`ifdef UART_TX_FIFO_BREAK_EN
      mab_q       <= mab_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three framing configurations driven in parallel, each
// compared every cycle against a frame-level model (queue + start time + frame vector).
module tb_uart_tx_fifo;
  localparam int N = 3;
  localparam int CPB [N] = '{4, 3, 2};
  localparam int DB  [N] = '{8, 7, 9};
  localparam int PM  [N] = '{0, 1, 2};
  localparam int SB  [N] = '{1, 1, 2};
  localparam int DEP [N] = '{4, 2, 8};

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dv;
  logic [8:0] tx_byte;
  logic       ser [N], act [N], done [N], rdy [N];
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;
  logic [3:0] cnt_c;
`ifdef UART_TX_FIFO_BREAK_EN
  logic       brk = 1'b0;
`endif

  uart_tx_fifo #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(DB[0]), .PARITY_MODE(PM[0]),
                 .STOP_BITS(SB[0]), .FIFO_DEPTH(DEP[0])) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte[7:0]),
`ifdef UART_TX_FIFO_BREAK_EN
    .i_Break(brk),
`endif
    .o_TX_Ready(rdy[0]), .o_FIFO_Count(cnt_a), .o_TX_Active(act[0]),
    .o_TX_Serial(ser[0]), .o_TX_Done(done[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(DB[1]), .PARITY_MODE(PM[1]),
                 .STOP_BITS(SB[1]), .FIFO_DEPTH(DEP[1])) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte[6:0]),
`ifdef UART_TX_FIFO_BREAK_EN
    .i_Break(brk),
`endif
    .o_TX_Ready(rdy[1]), .o_FIFO_Count(cnt_b), .o_TX_Active(act[1]),
    .o_TX_Serial(ser[1]), .o_TX_Done(done[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB[2]), .DATA_BITS(DB[2]), .PARITY_MODE(PM[2]),
                 .STOP_BITS(SB[2]), .FIFO_DEPTH(DEP[2])) dut_c (
    .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
`ifdef UART_TX_FIFO_BREAK_EN
    .i_Break(brk),
`endif
    .o_TX_Ready(rdy[2]), .o_FIFO_Count(cnt_c), .o_TX_Active(act[2]),
    .o_TX_Serial(ser[2]), .o_TX_Done(done[2]));

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int idx, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, idx, $time, got, exp);
  endtask

  // Serial image of one frame, bit 0 first: start, data LSB first, parity, stop ones.
  function automatic logic [15:0] frame_vec(input int i, input logic [8:0] b);
    logic [15:0] v;
    logic        p;
    v = '1;
    v[0] = 1'b0;
    p = 1'b0;
    for (int k = 0; k < DB[i]; k++) begin
      v[1 + k] = b[k];
      p ^= b[k];
    end
    if (PM[i] == 1)      v[1 + DB[i]] = p;
    else if (PM[i] == 2) v[1 + DB[i]] = ~p;
    return v;
  endfunction

  function automatic int frame_cycles(input int i);
    return (1 + DB[i] + ((PM[i] != 0) ? 1 : 0) + SB[i]) * CPB[i];
  endfunction

  // scoreboard: expected queue per instance plus the frame currently on the line
  logic [8:0]  exp_q [N][$];
  bit          busy [N];
  int          t [N];
  logic [15:0] fv [N];
  int          e_ser [N], e_act [N], e_done [N], e_cnt [N], e_rdy [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int pre;
      if (rst) begin
        exp_q[i].delete();
        busy[i]   = 1'b0;
        t[i]      = 0;
        e_done[i] = 0;
      end else begin
        pre = exp_q[i].size();
        e_done[i] = 0;
        if (busy[i]) begin
          t[i]++;
          if (t[i] == frame_cycles(i)) begin
            e_done[i] = 1;
            busy[i]   = 1'b0;
          end
        end
        if (!busy[i] && pre > 0) begin
          fv[i]   = frame_vec(i, exp_q[i].pop_front());
          busy[i] = 1'b1;
          t[i]    = 0;
        end
        if (dv && pre < DEP[i]) exp_q[i].push_back(tx_byte & 9'((1 << DB[i]) - 1));
      end
      e_ser[i] = busy[i] ? int'(fv[i][t[i] / CPB[i]]) : 1;
      e_act[i] = busy[i] ? 1 : 0;
      e_cnt[i] = exp_q[i].size();
      e_rdy[i] = (exp_q[i].size() < DEP[i]) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int gc [N];
      gc[0] = int'(cnt_a);
      gc[1] = int'(cnt_b);
      gc[2] = int'(cnt_c);
      for (int i = 0; i < N; i++) begin
        chk("serial", i, int'(ser[i]), e_ser[i]);
        chk("active", i, int'(act[i]), e_act[i]);
        chk("done",   i, int'(done[i]), e_done[i]);
        chk("count",  i, gc[i], e_cnt[i]);
        chk("ready",  i, int'(rdy[i]), e_rdy[i]);
      end
    end
  end

  // driver tasks
  task automatic drive(input bit v, input logic [8:0] b, input bit r);
    @(negedge clk);
    dv      = v;
    tx_byte = b;
    rst     = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 9'($urandom), 1'b0);
  endtask

  initial begin
    logic [15:0] v;
    logic [9:0]  sbits;
    int          done_at, act_n, done_n, low_n;

    rst = 1'b1;
    dv = 1'b0;
    tx_byte = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_serial", 0, int'(ser[0]), 1);
    chk("rst_active", 0, int'(act[0]), 0);
    chk("rst_count",  0, int'(cnt_a), 0);
    chk("rst_ready",  0, int'(rdy[0]), 1);

    v = frame_vec(0, 9'h0A5);
    chk("model_frame_a5", 0, int'(v[9:0]), 'b1101001010);
    v = frame_vec(1, 9'h007);
    chk("model_even_parity", 1, int'(v[8]), 1);
    v = frame_vec(2, 9'h007);
    chk("model_odd_parity", 2, int'(v[10]), 0);

    // single 0xA5: start one cycle after push, mid-bit samples, done at 40
    drive(1'b1, 9'h0A5, 1'b0);
    drive(1'b0, 9'h000, 1'b0);
    chk("a_line_high_at_push", 0, int'(ser[0]), 1);
    @(negedge clk);
    sbits = '0;
    done_at = -1;
    act_n = 0;
    done_n = 0;
    for (int k = 0; k < 60; k++) begin
      if (k % 4 == 2 && k / 4 < 10) sbits[k / 4] = ser[0];
      if (act[0]) act_n++;
      if (done[0]) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      @(negedge clk);
    end
    chk("a_bits_a5", 0, int'(sbits), 'b1101001010);
    chk("a_done_cycle", 0, done_at, 40);
    chk("a_done_pulses", 0, done_n, 1);
    chk("a_active_cycles", 0, act_n, 40);

    // six pushes back-to-back: five accepted, sixth dropped
    idle(20);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 9'(k * 37 + 11), 1'b0);
      if (k == 5) chk("a_ready_low_full", 0, int'(rdy[0]), 0);
    end
    act_n = 0;
    done_n = 0;
    for (int k = 0; k < 230; k++) begin
      drive(1'b0, 9'($urandom), 1'b0);
      if (act[0]) act_n++;
      if (done[0]) done_n++;
    end
    chk("a_burst_done_pulses", 0, done_n, 5);
    chk("a_burst_active_cycles", 0, act_n, 196);

    // reset at cycle 15 of a frame with three queued
    idle(20);
    for (int k = 0; k < 4; k++) drive(1'b1, 9'($urandom), 1'b0);
    idle(12);
    drive(1'b0, 9'h000, 1'b1);
    chk("a_queued_before_reset", 0, int'(cnt_a), 3);
    drive(1'b0, 9'h000, 1'b0);
    chk("a_reset_line", 0, int'(ser[0]), 1);
    chk("a_reset_count", 0, int'(cnt_a), 0);
    chk("a_reset_active", 0, int'(act[0]), 0);
    done_n = 0;
    low_n = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 9'($urandom), 1'b0);
      if (done[0]) done_n++;
      if (!ser[0]) low_n++;
    end
    chk("a_no_done_after_reset", 0, done_n, 0);
    chk("a_line_idle_after_reset", 0, low_n, 0);

    // randomized traffic at varying load with occasional reset
    for (int k = 0; k < 4000; k++) begin
      int pct;
      case (k / 1000)
        0:       pct = 10;
        1:       pct = 50;
        2:       pct = 90;
        default: pct = 30;
      endcase
      drive($urandom_range(99) < pct, 9'($urandom), $urandom_range(599) == 0);
    end
    idle(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
